// File: rtl/mips_cpu_bus_pkg.sv
// Shared types and constants for the MIPS CPU data-bus bridge.
//  - bridge_state_t : bridge FSM states
//  - avm_req_t      : registered Avalon-MM master request payload
//  - DEFAULT_ERR_DATA : load data returned on an aborted read
package mips_cpu_bus_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = 4;

    localparam logic [DATA_W-1:0] DEFAULT_ERR_DATA = 32'hDEADBEEF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        DONE = 2'd2
    } bridge_state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] address;
        logic [BE_W-1:0]   byteenable;
        logic [DATA_W-1:0] writedata;
        logic              read;
        logic              write;
    } avm_req_t;

endpackage

// File: rtl/mips_cpu_bus_timeout_counter.sv
// Saturating wait-state counter that flags when a bus access has waited too long.
// Ports:
//  clk, reset  clock and asynchronous active-low reset
//  clr         zero the count (takes priority over inc)
//  inc         count one more wait cycle
//  expired_c   count has reached TIMEOUT_CYCLES-1 (combinational from the count)
module mips_cpu_bus_timeout_counter #(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic inc,
    output logic expired_c
);

    localparam int unsigned     CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] MAX   = '1;

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: clear wins, increment saturates at all-ones.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != MAX)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_c = (count_q >= LAST);

endmodule

// File: rtl/mips_cpu_data_bus_bridge.sv
// Bridges the CPU's combinational-read / single-cycle-write data port onto an
// Avalon-MM master with waitrequest. The CPU is stalled via cpu_clk_enable
// until the bus access finishes; captured load data is then replayed.
// Every access is bounded by TIMEOUT_CYCLES of waitrequest.
// Ports:
//  clk, reset               clock, asynchronous active-low reset
//  host_clk_enable          clock enable from host
//  cpu_clk_enable           clock enable to CPU (low = stalled), combinational
//  cpu_data_*               CPU data port (address, read, write, byteenable, writedata, readdata)
//  avm_*                    Avalon-MM master (registered address/strobes/byteenable/writedata)
//  bus_error                sticky timeout flag, cleared only by reset
module mips_cpu_data_bus_bridge
    import mips_cpu_bus_pkg::*;
#(
    parameter int unsigned       TIMEOUT_CYCLES = 256,
    parameter logic [DATA_W-1:0] ERR_DATA       = DEFAULT_ERR_DATA
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              host_clk_enable,
    output logic              cpu_clk_enable,
    input  logic [ADDR_W-1:0] cpu_data_address,
    input  logic              cpu_data_read,
    input  logic              cpu_data_write,
    input  logic [BE_W-1:0]   cpu_data_byteenable,
    input  logic [DATA_W-1:0] cpu_data_writedata,
    output logic [DATA_W-1:0] cpu_data_readdata,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_read,
    output logic              avm_write,
    output logic [BE_W-1:0]   avm_byteenable,
    output logic [DATA_W-1:0] avm_writedata,
    input  logic [DATA_W-1:0] avm_readdata,
    input  logic              avm_waitrequest,
    output logic              bus_error
);

    bridge_state_t     state_q,     state_d;
    avm_req_t          avm_q,       avm_d;
    logic [DATA_W-1:0] rdata_q,     rdata_d;
    logic              bus_error_q, bus_error_d;

    logic req_c;
    logic cnt_clr;
    logic cnt_inc;
    logic cnt_expired_c;

    assign req_c = cpu_data_read | cpu_data_write;

    mips_cpu_bus_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk       (clk),
        .reset     (reset),
        .clr       (cnt_clr),
        .inc       (cnt_inc),
        .expired_c (cnt_expired_c)
    );

    // Next-state, bus request and capture logic.
    always_comb begin
        state_d     = state_q;
        avm_d       = avm_q;
        rdata_d     = rdata_q;
        bus_error_d = bus_error_q;
        cnt_clr     = 1'b0;
        cnt_inc     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (req_c) begin
                    avm_d.address    = cpu_data_address;
                    avm_d.byteenable = cpu_data_byteenable;
                    avm_d.writedata  = cpu_data_writedata;
                    avm_d.write      = cpu_data_write;
                    // A simultaneous write suppresses the read.
                    avm_d.read       = cpu_data_read & ~cpu_data_write;
                    state_d          = BUS;
                end
            end
            BUS: begin
                if (!avm_waitrequest) begin
                    if (avm_q.read) begin
                        rdata_d = avm_readdata;
                    end
                    avm_d.read  = 1'b0;
                    avm_d.write = 1'b0;
                    state_d     = DONE;
                end else if (cnt_expired_c) begin
                    // Abort: slave has stalled too long.
                    if (avm_q.read) begin
                        rdata_d = ERR_DATA;
                    end
                    avm_d.read  = 1'b0;
                    avm_d.write = 1'b0;
                    bus_error_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            DONE: begin
                // Hold until the host lets the CPU commit this access.
                if (host_clk_enable) begin
                    cnt_clr = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            avm_q       <= '0;
            rdata_q     <= '0;
            bus_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            avm_q       <= avm_d;
            rdata_q     <= rdata_d;
            bus_error_q <= bus_error_d;
        end
    end

    assign avm_address    = avm_q.address;
    assign avm_read       = avm_q.read;
    assign avm_write      = avm_q.write;
    assign avm_byteenable = avm_q.byteenable;
    assign avm_writedata  = avm_q.writedata;
    assign bus_error      = bus_error_q;

    // A new request stalls the CPU in the same cycle it is seen.
    assign cpu_clk_enable    = host_clk_enable &
                               (((state_q == IDLE) & ~req_c) | (state_q == DONE));
    assign cpu_data_readdata = (state_q == DONE) ? rdata_q : '0;

endmodule

// File: tb/tb_mips_cpu_data_bus_bridge.sv
// Self-checking bench for mips_cpu_data_bus_bridge: directed table, hand
// sequences for reset and host stall, and randomized accesses against a
// transaction-level model.
module tb_mips_cpu_data_bus_bridge;

    localparam int unsigned T = 8;
    localparam logic [31:0] ERR = 32'hDEADBEEF;

    logic        clk = 1'b0;
    logic        reset;
    logic        host_clk_enable;
    logic        cpu_clk_enable;
    logic [31:0] cpu_data_address;
    logic        cpu_data_read;
    logic        cpu_data_write;
    logic [3:0]  cpu_data_byteenable;
    logic [31:0] cpu_data_writedata;
    logic [31:0] cpu_data_readdata;
    logic [31:0] avm_address;
    logic        avm_read;
    logic        avm_write;
    logic [3:0]  avm_byteenable;
    logic [31:0] avm_writedata;
    logic [31:0] avm_readdata;
    logic        avm_waitrequest;
    logic        bus_error;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mips_cpu_data_bus_bridge #(
        .TIMEOUT_CYCLES (T),
        .ERR_DATA       (ERR)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .host_clk_enable     (host_clk_enable),
        .cpu_clk_enable      (cpu_clk_enable),
        .cpu_data_address    (cpu_data_address),
        .cpu_data_read       (cpu_data_read),
        .cpu_data_write      (cpu_data_write),
        .cpu_data_byteenable (cpu_data_byteenable),
        .cpu_data_writedata  (cpu_data_writedata),
        .cpu_data_readdata   (cpu_data_readdata),
        .avm_address         (avm_address),
        .avm_read            (avm_read),
        .avm_write           (avm_write),
        .avm_byteenable      (avm_byteenable),
        .avm_writedata       (avm_writedata),
        .avm_readdata        (avm_readdata),
        .avm_waitrequest     (avm_waitrequest),
        .bus_error           (bus_error)
    );

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wd;
        int          waits;      // cycles waitrequest stays high in BUS
        logic [31:0] rdata;      // slave data on the accepting cycle
        logic        exp_rd;
        logic        exp_wr;
        int          exp_stall;  // cycles cpu_clk_enable is low
        logic [31:0] exp_rdata;  // load data shown in DONE
        logic        exp_err;
    } vec_t;

    vec_t tbl [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        cpu_data_read       = 1'b0;
        cpu_data_write      = 1'b0;
        cpu_data_address    = 32'h0;
        cpu_data_byteenable = 4'h0;
        cpu_data_writedata  = 32'h0;
        avm_waitrequest     = 1'b1;
        avm_readdata        = 32'h0;
    endtask

    // Called just after a posedge with the bridge in IDLE and host_clk_enable=1.
    task automatic run_txn(input vec_t v);
        int bus_n;
        bus_n = v.exp_stall - 1;
        cpu_data_read       = v.rd;
        cpu_data_write      = v.wr;
        cpu_data_address    = v.addr;
        cpu_data_byteenable = v.be;
        cpu_data_writedata  = v.wd;
        avm_waitrequest     = 1'b1;
        avm_readdata        = $urandom;
        @(negedge clk);
        chk("idle_detect_cce", 32'(cpu_clk_enable), 32'h0);
        chk("idle_detect_rd", 32'(avm_read), 32'h0);
        chk("idle_detect_wr", 32'(avm_write), 32'h0);
        for (int n = 1; n <= bus_n; n++) begin
            @(posedge clk); #1;
            avm_waitrequest = (n <= v.waits);
            avm_readdata    = (n == v.waits + 1) ? v.rdata : $urandom;
            @(negedge clk);
            chk("bus_rd", 32'(avm_read), 32'(v.exp_rd));
            chk("bus_wr", 32'(avm_write), 32'(v.exp_wr));
            chk("bus_addr", avm_address, v.addr);
            chk("bus_be", 32'(avm_byteenable), 32'(v.be));
            chk("bus_wd", avm_writedata, v.wd);
            chk("bus_cce", 32'(cpu_clk_enable), 32'h0);
            chk("bus_cpu_rdata", cpu_data_readdata, 32'h0);
        end
        @(posedge clk); #1;
        avm_waitrequest = 1'b1;
        avm_readdata    = $urandom;
        @(negedge clk);
        chk("done_cce", 32'(cpu_clk_enable), 32'h1);
        chk("done_rdata", cpu_data_readdata, v.exp_rdata);
        chk("done_rd", 32'(avm_read), 32'h0);
        chk("done_wr", 32'(avm_write), 32'h0);
        chk("done_err", 32'(bus_error), 32'(v.exp_err));
        @(posedge clk); #1;
        idle_inputs();
    endtask

    // Transaction-level model state.
    logic [31:0] m_cap;
    logic        m_err;

    function automatic vec_t model(input logic rd, input logic wr, input logic [31:0] addr,
                                   input logic [3:0] be, input logic [31:0] wd,
                                   input int waits, input logic [31:0] rdata);
        vec_t v;
        bit   tmo;
        int   bus_n;
        v.rd = rd; v.wr = wr; v.addr = addr; v.be = be; v.wd = wd;
        v.waits = waits; v.rdata = rdata;
        tmo   = (waits >= int'(T));
        bus_n = tmo ? int'(T) : waits + 1;
        v.exp_wr    = wr;
        v.exp_rd    = rd & ~wr;
        v.exp_stall = bus_n + 1;
        if (v.exp_rd) m_cap = tmo ? ERR : rdata;
        if (tmo) m_err = 1'b1;
        v.exp_rdata = m_cap;
        v.exp_err   = m_err;
        return v;
    endfunction

    initial begin
        logic [31:0] r;
        int          sel;
        int          w;
        int          gap;
        vec_t        v;

        tbl[0] = '{1'b1, 1'b0, 32'h0000_1000, 4'hF, 32'h0, 0, 32'h1234_5678,
                   1'b1, 1'b0, 2, 32'h1234_5678, 1'b0};
        tbl[1] = '{1'b0, 1'b1, 32'h0000_2004, 4'h3, 32'h0000_BEEF, 5, 32'h0,
                   1'b0, 1'b1, 7, 32'h1234_5678, 1'b0};
        tbl[2] = '{1'b1, 1'b0, 32'h0000_3000, 4'hF, 32'h0, 20, 32'h0,
                   1'b1, 1'b0, 9, 32'hDEAD_BEEF, 1'b1};
        tbl[3] = '{1'b1, 1'b1, 32'h0000_0010, 4'hF, 32'hA5A5_A5A5, 0, 32'h0,
                   1'b0, 1'b1, 2, 32'hDEAD_BEEF, 1'b1};

        reset = 1'b0;
        host_clk_enable = 1'b1;
        idle_inputs();
        @(negedge clk);
        chk("rst_rd", 32'(avm_read), 32'h0);
        chk("rst_wr", 32'(avm_write), 32'h0);
        chk("rst_addr", avm_address, 32'h0);
        chk("rst_err", 32'(bus_error), 32'h0);
        chk("rst_cpu_rdata", cpu_data_readdata, 32'h0);
        chk("rst_cce", 32'(cpu_clk_enable), 32'h1);
        @(posedge clk); #1;
        reset = 1'b1;

        for (int i = 0; i < 4; i++) run_txn(tbl[i]);

        // Asynchronous reset in the middle of a stalled access.
        cpu_data_read       = 1'b1;
        cpu_data_address    = 32'h0000_0040;
        cpu_data_byteenable = 4'hF;
        @(posedge clk); #1;
        @(negedge clk);
        chk("pre_rst_rd", 32'(avm_read), 32'h1);
        #2;
        reset = 1'b0;
        #1;
        chk("async_rst_rd", 32'(avm_read), 32'h0);
        chk("async_rst_addr", avm_address, 32'h0);
        chk("async_rst_err", 32'(bus_error), 32'h0);
        idle_inputs();
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        chk("post_rst_cce_hi", 32'(cpu_clk_enable), 32'h1);
        host_clk_enable = 1'b0;
        #1;
        chk("post_rst_cce_lo", 32'(cpu_clk_enable), 32'h0);
        m_cap = 32'h0;
        m_err = 1'b0;

        // Host holds the CPU while the access completes on the bus.
        @(posedge clk); #1;
        cpu_data_read       = 1'b1;
        cpu_data_address    = 32'h0000_0080;
        cpu_data_byteenable = 4'hF;
        @(negedge clk);
        chk("hs_idle_cce", 32'(cpu_clk_enable), 32'h0);
        @(posedge clk); #1;
        avm_waitrequest = 1'b0;
        avm_readdata    = 32'hCAFE_F00D;
        @(negedge clk);
        chk("hs_bus_rd", 32'(avm_read), 32'h1);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            avm_waitrequest = 1'b1;
            avm_readdata    = $urandom;
            @(negedge clk);
            chk("hs_hold_cce", 32'(cpu_clk_enable), 32'h0);
            chk("hs_hold_rd", 32'(avm_read), 32'h0);
            chk("hs_hold_rdata", cpu_data_readdata, 32'hCAFE_F00D);
        end
        @(posedge clk); #1;
        host_clk_enable = 1'b1;
        @(negedge clk);
        chk("hs_release_cce", 32'(cpu_clk_enable), 32'h1);
        m_cap = 32'hCAFE_F00D;
        @(posedge clk); #1;
        // Next access back-to-back: enable must drop again immediately.
        run_txn(model(1'b1, 1'b0, 32'h0000_0084, 4'hF, 32'h0, 0, 32'h0BAD_F00D));

        // Randomized accesses against the model.
        for (int i = 0; i < 40; i++) begin
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                host_clk_enable = 1'($urandom_range(0, 1));
                @(negedge clk);
                chk("gap_cce", 32'(cpu_clk_enable), 32'(host_clk_enable));
                chk("gap_rdata", cpu_data_readdata, 32'h0);
                @(posedge clk); #1;
            end
            host_clk_enable = 1'b1;
            sel = $urandom_range(0, 2);
            r   = $urandom;
            w   = ($urandom_range(0, 4) == 0) ? $urandom_range(6, 10) : $urandom_range(0, 3);
            v   = model((sel != 1), (sel != 0), {r[31:2], 2'b00}, 4'($urandom_range(0, 15)),
                        $urandom, w, $urandom);
            run_txn(v);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
